// File: rtl/ucie_rdi_arb_pkg.sv
// Shared types and constants for the RDI transmit arbiter and its
// round-robin helper.
package ucie_rdi_arb_pkg;

    localparam int RDI_EMPTY_W = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        XFER  = 2'd1,
        STALL = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ucie_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or above ptr,
// wrapping modulo N; returns a one-hot grant and the granted index.
module ucie_rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] idx
);

    int   pos_s;
    logic take_s;
    logic found_s;

    // Scan N positions starting at ptr; the first hit wins.
    always_comb begin
        grant   = '0;
        idx     = '0;
        pos_s   = 0;
        take_s  = 1'b0;
        found_s = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos_s       = (int'(ptr) + k) % N;
            take_s      = req[pos_s] & ~found_s;
            grant[pos_s] = take_s;
            idx         = take_s ? PW'(pos_s) : idx;
            found_s     = found_s | take_s;
        end
    end

endmodule

// File: rtl/ucie_rdi_tx_arbiter.sv
// Packet-level round-robin arbiter sharing the RDI tx datapath among NUM_SRC
// sources; stalls are acknowledged only on packet boundaries.
module ucie_rdi_tx_arbiter
    import ucie_rdi_arb_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 16
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [NUM_SRC-1:0]                src_valid,
    input  logic [NUM_SRC*DATA_WIDTH-1:0]     src_data,
    input  logic [NUM_SRC*USER_WIDTH-1:0]     src_user,
    input  logic [NUM_SRC-1:0]                src_sop,
    input  logic [NUM_SRC-1:0]                src_eop,
    input  logic [NUM_SRC*RDI_EMPTY_W-1:0]    src_empty,
    output logic [NUM_SRC-1:0]                src_ready,
    output logic                              tx_valid,
    output logic [DATA_WIDTH-1:0]             tx_data,
    output logic [USER_WIDTH-1:0]             tx_user,
    output logic                              tx_sop,
    output logic                              tx_eop,
    output logic [RDI_EMPTY_W-1:0]            tx_empty,
    input  logic                              tx_ready,
    input  logic                              link_up,
    input  logic                              pl_stallreq,
    output logic                              lp_stallack,
    output logic [$clog2(NUM_SRC)-1:0]        grant_id,
    output logic                              busy,
    output logic                              abort_pulse
);

    localparam int IDW = $clog2(NUM_SRC);

    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_XFER  = XFER;
    localparam logic [1:0] ST_STALL = STALL;

    logic [1:0]         state_r;
    logic [1:0]         state_nxt_s;
    logic [IDW-1:0]     rr_ptr_r;
    logic [IDW-1:0]     grant_id_r;
    logic               stallack_r;
    logic               busy_r;
    logic               abort_r;

    logic [NUM_SRC-1:0] elig_s;
    logic [NUM_SRC-1:0] arb_gnt_s;
    logic [IDW-1:0]     arb_idx_s;
    logic               grant_take_s;
    logic               live_s;
    logic               eop_hs_s;

    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] i);
        return (i == IDW'(NUM_SRC - 1)) ? IDW'(0) : i + IDW'(1);
    endfunction

    assign elig_s = src_valid & src_sop;

    ucie_rr_arbiter #(
        .N  (NUM_SRC),
        .PW (IDW)
    ) u_rr (
        .req   (elig_s),
        .ptr   (rr_ptr_r),
        .grant (arb_gnt_s),
        .idx   (arb_idx_s)
    );

    // Zero-latency datapath mux from the granted source.
    always_comb begin
        tx_data  = src_data[grant_id_r*DATA_WIDTH +: DATA_WIDTH];
        tx_user  = src_user[grant_id_r*USER_WIDTH +: USER_WIDTH];
        tx_empty = src_empty[grant_id_r*RDI_EMPTY_W +: RDI_EMPTY_W];
        tx_sop   = src_sop[grant_id_r];
        tx_eop   = src_eop[grant_id_r];
    end

    // Losing link_up mid-packet cuts the handshake in the same cycle.
    assign live_s   = (state_r == ST_XFER) & link_up;
    assign tx_valid = live_s & src_valid[grant_id_r];
    assign eop_hs_s = tx_valid & tx_ready & tx_eop;

    // Only the granted source sees tx_ready, and only while the link is live.
    always_comb begin
        src_ready = '0;
        if (live_s) begin
            src_ready[grant_id_r] = tx_ready;
        end else begin
            src_ready = '0;
        end
    end

    // Next-state logic; a pending stall request wins over new grants.
    always_comb begin
        state_nxt_s  = state_r;
        grant_take_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pl_stallreq) begin
                    state_nxt_s = ST_STALL;
                end else if (link_up && (|arb_gnt_s)) begin
                    state_nxt_s  = ST_XFER;
                    grant_take_s = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_XFER: begin
                if (!link_up) begin
                    state_nxt_s = ST_IDLE;
                end else if (eop_hs_s) begin
                    state_nxt_s = pl_stallreq ? ST_STALL : ST_IDLE;
                end else begin
                    state_nxt_s = ST_XFER;
                end
            end
            ST_STALL: begin
                if (!pl_stallreq) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_STALL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, pointer and registered status outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r    <= ST_IDLE;
            rr_ptr_r   <= '0;
            grant_id_r <= '0;
            stallack_r <= 1'b0;
            busy_r     <= 1'b0;
            abort_r    <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            stallack_r <= (state_nxt_s == ST_STALL);
            busy_r     <= (state_nxt_s == ST_XFER);
            abort_r    <= (state_r == ST_XFER) & ~link_up;
            if (grant_take_s) begin
                grant_id_r <= arb_idx_s;
                rr_ptr_r   <= next_ptr(arb_idx_s);
            end
        end
    end

    assign lp_stallack = stallack_r;
    assign grant_id    = grant_id_r;
    assign busy        = busy_r;
    assign abort_pulse = abort_r;

endmodule

// File: tb/tb_ucie_rdi_tx_arbiter.sv
// Directed, table-driven bench for ucie_rdi_tx_arbiter (4 sources, narrow data).
module tb_ucie_rdi_tx_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int UW = 8;

    logic              clk;
    logic              resetn;
    logic [NS-1:0]     src_valid;
    logic [NS*DW-1:0]  src_data;
    logic [NS*UW-1:0]  src_user;
    logic [NS-1:0]     src_sop;
    logic [NS-1:0]     src_eop;
    logic [NS*6-1:0]   src_empty;
    logic [NS-1:0]     src_ready;
    logic              tx_valid;
    logic [DW-1:0]     tx_data;
    logic [UW-1:0]     tx_user;
    logic              tx_sop;
    logic              tx_eop;
    logic [5:0]        tx_empty;
    logic              tx_ready;
    logic              link_up;
    logic              pl_stallreq;
    logic              lp_stallack;
    logic [1:0]        grant_id;
    logic              busy;
    logic              abort_pulse;

    ucie_rdi_tx_arbiter #(.NUM_SRC(NS), .DATA_WIDTH(DW), .USER_WIDTH(UW)) dut (
        .clk(clk), .resetn(resetn),
        .src_valid(src_valid), .src_data(src_data), .src_user(src_user),
        .src_sop(src_sop), .src_eop(src_eop), .src_empty(src_empty),
        .src_ready(src_ready),
        .tx_valid(tx_valid), .tx_data(tx_data), .tx_user(tx_user),
        .tx_sop(tx_sop), .tx_eop(tx_eop), .tx_empty(tx_empty),
        .tx_ready(tx_ready), .link_up(link_up),
        .pl_stallreq(pl_stallreq), .lp_stallack(lp_stallack),
        .grant_id(grant_id), .busy(busy), .abort_pulse(abort_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] v, s, e;
        logic       txr, link, st;
        logic       txv;
        logic [3:0] rdy;
        logic [1:0] gid;
        logic       ack, bsy, abt;
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [DW-1:0] pdata(input int i);
        return 32'hD0C0_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    function automatic logic [UW-1:0] puser(input int i);
        return 8'h10 + 8'(i);
    endfunction

    function automatic logic [5:0] pempty(input int i);
        return 6'(i + 1);
    endfunction

    task automatic add(input logic [3:0] v, s, e, input logic txr, link, st,
                       input logic txv, input logic [3:0] rdy, input logic [1:0] gid,
                       input logic ack, bsy, abt);
        vec_t r;
        r.v = v; r.s = s; r.e = e; r.txr = txr; r.link = link; r.st = st;
        r.txv = txv; r.rdy = rdy; r.gid = gid; r.ack = ack; r.bsy = bsy; r.abt = abt;
        vq.push_back(r);
    endtask

    task automatic check(input string name, input logic txv, input logic [3:0] rdy,
                         input logic [1:0] gid, input logic ack, bsy, abt);
        logic [9:0]  act, exp;
        logic [47:0] dact, dexp;
        logic        bad;
        act  = {tx_valid, src_ready, grant_id, lp_stallack, busy, abort_pulse};
        exp  = {txv, rdy, gid, ack, bsy, abt};
        dact = {tx_data, tx_user, tx_sop, tx_eop, tx_empty};
        dexp = {pdata(int'(gid)), puser(int'(gid)), src_sop[gid], src_eop[gid], pempty(int'(gid))};
        bad  = (act !== exp) || (txv && (dact !== dexp));
        n_vec++;
        if (bad) begin
            n_err++;
            $display("FAIL %s: got {txv,rdy,gid,ack,busy,abort}=%b data=%h, expected %b data=%h",
                     name, act, dact, exp, txv ? dexp : dact);
        end
    endtask

    task automatic run_table(input string tag);
        foreach (vq[i]) begin
            @(negedge clk);
            src_valid   = vq[i].v;
            src_sop     = vq[i].s;
            src_eop     = vq[i].e;
            tx_ready    = vq[i].txr;
            link_up     = vq[i].link;
            pl_stallreq = vq[i].st;
            #1;
            check($sformatf("%s[%0d]", tag, i), vq[i].txv, vq[i].rdy, vq[i].gid,
                  vq[i].ack, vq[i].bsy, vq[i].abt);
        end
        vq.delete();
    endtask

    initial begin
        resetn = 1'b0; src_valid = '0; src_sop = '0; src_eop = '0;
        tx_ready = 1'b1; link_up = 1'b1; pl_stallreq = 1'b0;
        for (int i = 0; i < NS; i++) begin
            src_data[i*DW +: DW]  = pdata(i);
            src_user[i*UW +: UW]  = puser(i);
            src_empty[i*6 +: 6]   = pempty(i);
        end
        #12;
        check("reset_state", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        resetn = 1'b1;

        // Two-beat packets from src0 and src2, then src3/src0 proving rr_ptr=3.
        add(4'b0101, 4'b0101, 4'b0000, 1, 1, 0, 0, 4'b0000, 2'd0, 0, 0, 0);
        add(4'b0101, 4'b0101, 4'b0000, 1, 1, 0, 1, 4'b0001, 2'd0, 0, 1, 0);
        add(4'b0101, 4'b0100, 4'b0001, 1, 1, 0, 1, 4'b0001, 2'd0, 0, 1, 0);
        add(4'b0100, 4'b0100, 4'b0000, 1, 1, 0, 0, 4'b0000, 2'd0, 0, 0, 0);
        add(4'b0100, 4'b0100, 4'b0000, 1, 1, 0, 1, 4'b0100, 2'd2, 0, 1, 0);
        add(4'b0100, 4'b0000, 4'b0100, 1, 1, 0, 1, 4'b0100, 2'd2, 0, 1, 0);
        add(4'b1001, 4'b1001, 4'b1001, 1, 1, 0, 0, 4'b0000, 2'd2, 0, 0, 0);
        add(4'b1001, 4'b1001, 4'b1001, 1, 1, 0, 1, 4'b1000, 2'd3, 0, 1, 0);
        add(4'b0001, 4'b0001, 4'b0001, 1, 1, 0, 0, 4'b0000, 2'd3, 0, 0, 0);
        add(4'b0001, 4'b0001, 4'b0001, 1, 1, 0, 1, 4'b0001, 2'd0, 0, 1, 0);
        add(4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0, 4'b0000, 2'd0, 0, 0, 0);
        run_table("two_src");

        // Asynchronous reset in the middle of a src1 packet.
        @(negedge clk);
        src_valid = 4'b0010; src_sop = 4'b0010; src_eop = 4'b0000;
        #1;
        check("rst_pre_idle", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        check("rst_pre_xfer", 1'b1, 4'b0010, 2'd1, 1'b0, 1'b1, 1'b0);
        #1 resetn = 1'b0;
        #1;
        check("rst_async", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        src_valid = '0; src_sop = '0; src_eop = '0;
        resetn = 1'b1;
        #1;
        check("rst_release", 1'b0, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);

        // All four sources with back-to-back single-beat packets.
        for (int k = 0; k < 5; k++) begin
            add(4'b1111, 4'b1111, 4'b1111, 1, 1, 0, 0, 4'b0000, (k == 0) ? 2'd0 : 2'(k - 1), 0, 0, 0);
            add(4'b1111, 4'b1111, 4'b1111, 1, 1, 0, 1, 4'b0001 << (k % 4), 2'(k % 4), 0, 1, 0);
        end
        add(4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0, 4'b0000, 2'd0, 0, 0, 0);
        run_table("rotate");

        // Stall raised mid-packet, then stall raised in IDLE.
        add(4'b0010, 4'b0010, 4'b0000, 1, 1, 0, 0, 4'b0000, 2'd0, 0, 0, 0);
        add(4'b0010, 4'b0010, 4'b0000, 1, 1, 0, 1, 4'b0010, 2'd1, 0, 1, 0);
        add(4'b0010, 4'b0000, 4'b0000, 1, 1, 1, 1, 4'b0010, 2'd1, 0, 1, 0);
        add(4'b0010, 4'b0000, 4'b0000, 1, 1, 1, 1, 4'b0010, 2'd1, 0, 1, 0);
        add(4'b0010, 4'b0000, 4'b0010, 1, 1, 1, 1, 4'b0010, 2'd1, 0, 1, 0);
        add(4'b0001, 4'b0001, 4'b0001, 1, 1, 1, 0, 4'b0000, 2'd1, 1, 0, 0);
        add(4'b0001, 4'b0001, 4'b0001, 1, 1, 1, 0, 4'b0000, 2'd1, 1, 0, 0);
        add(4'b0001, 4'b0001, 4'b0001, 1, 1, 0, 0, 4'b0000, 2'd1, 1, 0, 0);
        add(4'b0001, 4'b0001, 4'b0001, 1, 1, 0, 0, 4'b0000, 2'd1, 0, 0, 0);
        add(4'b0001, 4'b0001, 4'b0001, 1, 1, 0, 1, 4'b0001, 2'd0, 0, 1, 0);
        add(4'b0000, 4'b0000, 4'b0000, 1, 1, 1, 0, 4'b0000, 2'd0, 0, 0, 0);
        add(4'b0010, 4'b0010, 4'b0010, 1, 1, 1, 0, 4'b0000, 2'd0, 1, 0, 0);
        add(4'b0010, 4'b0010, 4'b0010, 1, 1, 0, 0, 4'b0000, 2'd0, 1, 0, 0);
        add(4'b0010, 4'b0010, 4'b0010, 1, 1, 0, 0, 4'b0000, 2'd0, 0, 0, 0);
        add(4'b0010, 4'b0010, 4'b0010, 1, 1, 0, 1, 4'b0010, 2'd1, 0, 1, 0);
        add(4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0, 4'b0000, 2'd1, 0, 0, 0);
        run_table("stall");

        // link_up loss on beat 2 of a src1 packet; src3 valid without sop.
        add(4'b0010, 4'b0010, 4'b0000, 1, 1, 0, 0, 4'b0000, 2'd1, 0, 0, 0);
        add(4'b0010, 4'b0010, 4'b0000, 1, 1, 0, 1, 4'b0010, 2'd1, 0, 1, 0);
        add(4'b0010, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 2'd1, 0, 1, 0);
        add(4'b0010, 4'b0000, 4'b0000, 1, 0, 0, 0, 4'b0000, 2'd1, 0, 0, 1);
        add(4'b1010, 4'b0000, 4'b0000, 1, 1, 0, 0, 4'b0000, 2'd1, 0, 0, 0);
        add(4'b1010, 4'b0000, 4'b0000, 1, 1, 0, 0, 4'b0000, 2'd1, 0, 0, 0);
        add(4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0, 4'b0000, 2'd1, 0, 0, 0);
        run_table("link_drop");

        // tx_ready backpressure for 5 cycles with a competing src0 request.
        add(4'b0100, 4'b0100, 4'b0000, 1, 1, 0, 0, 4'b0000, 2'd1, 0, 0, 0);
        add(4'b0100, 4'b0100, 4'b0000, 1, 1, 0, 1, 4'b0100, 2'd2, 0, 1, 0);
        for (int k = 0; k < 5; k++)
            add(4'b0101, 4'b0001, 4'b0001, 0, 1, 0, 1, 4'b0000, 2'd2, 0, 1, 0);
        add(4'b0101, 4'b0001, 4'b0001, 1, 1, 0, 1, 4'b0100, 2'd2, 0, 1, 0);
        add(4'b0101, 4'b0001, 4'b0101, 1, 1, 0, 1, 4'b0100, 2'd2, 0, 1, 0);
        add(4'b0001, 4'b0001, 4'b0001, 1, 1, 0, 0, 4'b0000, 2'd2, 0, 0, 0);
        add(4'b0001, 4'b0001, 4'b0001, 1, 1, 0, 1, 4'b0001, 2'd0, 0, 1, 0);
        add(4'b0000, 4'b0000, 4'b0000, 1, 1, 0, 0, 4'b0000, 2'd0, 0, 0, 0);
        run_table("backpressure");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
